// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU memory path: bus word, RAM handshake
// states and the memory arbiter's FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ISRV = 2'd1,
        DSRV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Data wins by default; a streak counter bounds fetch starvation.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int FAIR_N    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              bus_err
);

    localparam int SW = $clog2(FAIR_N + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_N);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    arb_state_t        state_q;
    logic [SW-1:0]     dstreak_q;
    logic [RW-1:0]     retry_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic              ren_q;
    logic              wen_q;

    ramstate_t rs;
    logic      serving;
    logic      give_up;
    logic      finish;
    logic      d_pending;
    logic      grant_data;

    assign rs         = ramstate_t'(ramstate);
    assign serving    = (state_q == ISRV) || (state_q == DSRV);
    assign give_up    = (rs == ERROR) && (retry_q == RETRY_MAX);
    assign finish     = (rs == ACCESS) || give_up;
    assign d_pending  = dREN || dWEN;
    // Data wins unless it has already taken FAIR_N grants past a waiting fetch.
    assign grant_data = d_pending && !(iREN && (dstreak_q == STREAK_MAX));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            store_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        state_q   <= DSRV;
                        addr_q    <= daddr;
                        store_q   <= dstore;
                        wen_q     <= dWEN;
                        ren_q     <= !dWEN;
                        retry_q   <= '0;
                        dstreak_q <= !iREN                    ? '0 :
                                     (dstreak_q == STREAK_MAX) ? STREAK_MAX :
                                                                 dstreak_q + 1'b1;
                    end else if (iREN) begin
                        state_q   <= ISRV;
                        addr_q    <= iaddr;
                        store_q   <= '0;
                        wen_q     <= 1'b0;
                        ren_q     <= 1'b1;
                        retry_q   <= '0;
                        dstreak_q <= '0;
                    end
                end
                ISRV, DSRV: begin
                    if (finish) begin
                        state_q <= IDLE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end else if (rs == ERROR) begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // Completion signalling is combinational so the requester sees it in the
    // same cycle the RAM reports ACCESS or the final ERROR.
    assign iwait   = !((state_q == ISRV) && finish);
    assign dwait   = !((state_q == DSRV) && finish);
    assign iload   = ((state_q == ISRV) && (rs == ACCESS)) ? ramload : '0;
    assign dload   = ((state_q == DSRV) && (rs == ACCESS)) ? ramload : '0;
    assign bus_err = serving && give_up;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: single-transaction vector table plus
// hand-written reset, priority, fairness and mid-transaction reset sequences.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    memory_arbiter #(.WORD_W(32), .FAIR_N(4), .MAX_RETRY(3)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .bus_err(bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        int          nbusy;
        int          nerr;
        logic        exp_ramren;
        logic        exp_ramwen;
        logic [31:0] exp_load;
        logic        exp_berr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Entered at a negedge in IDLE; leaves at a negedge in IDLE with requests low.
    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        int   lat;
        logic fin;
        logic wt;
        logic ow;
        logic [31:0] ld;
        k   = 0;
        lat = 1;
        fin = 1'b0;
        if (v.is_d) begin
            dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.store;
        end else begin
            iREN = 1'b1; iaddr = v.addr;
        end
        ramload = v.rdata;
        next_cycle();
        while (!fin && k < 20) begin
            if (k < v.nbusy)               ramstate = BUSY;
            else if (k < v.nbusy + v.nerr) ramstate = ERROR;
            else                           ramstate = ACCESS;
            lat++;
            @(negedge CLK);
            check($sformatf("v%0d ramREN", idx), ramREN, v.exp_ramren);
            check($sformatf("v%0d ramWEN", idx), ramWEN, v.exp_ramwen);
            check($sformatf("v%0d ramaddr", idx), ramaddr, v.addr);
            if (v.exp_ramwen) check($sformatf("v%0d ramstore", idx), ramstore, v.store);
            wt = v.is_d ? dwait : iwait;
            ow = v.is_d ? iwait : dwait;
            ld = v.is_d ? dload : iload;
            check($sformatf("v%0d other_wait", idx), ow, 1'b1);
            if (!wt) begin
                check($sformatf("v%0d load", idx), ld, v.exp_load);
                check($sformatf("v%0d bus_err", idx), bus_err, v.exp_berr);
                check($sformatf("v%0d latency", idx), lat, v.exp_lat);
                fin = 1'b1;
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            end else begin
                check($sformatf("v%0d load_quiet", idx), ld, 32'h0);
                check($sformatf("v%0d bus_err_quiet", idx), bus_err, 1'b0);
                next_cycle();
            end
            k++;
        end
        check($sformatf("v%0d completed", idx), fin, 1'b1);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        next_cycle();
        ramstate = FREE;
        @(negedge CLK);
        check($sformatf("v%0d exit_ren", idx), ramREN, 1'b0);
        check($sformatf("v%0d exit_wen", idx), ramWEN, 1'b0);
        check($sformatf("v%0d exit_iwait", idx), iwait, 1'b1);
        check($sformatf("v%0d exit_dwait", idx), dwait, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pat;
        int g;
        int cyc;
        logic is_f;

        //          is_d ren  wen  addr          store         rdata         busy err ren  wen  load          berr lat
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'h1111_1111, 0, 0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h200, 32'h0,        32'h2222_2222, 1, 0, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 3};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h40,  32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 5};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h44,  32'h1234_5678, 32'h0,         0, 0, 1'b0, 1'b1, 32'h0,         1'b0, 2};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h0,        32'h3333_3333, 0, 2, 1'b1, 1'b0, 32'h3333_3333, 1'b0, 4};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h0,        32'h4444_4444, 0, 4, 1'b1, 1'b0, 32'h0,         1'b1, 5};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h208, 32'h0,        32'h5555_5555, 0, 3, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 5};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h20C, 32'h0,        32'h6666_6666, 0, 4, 1'b1, 1'b0, 32'h0,         1'b1, 5};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h210, 32'h0,        32'h7777_7777, 2, 1, 1'b1, 1'b0, 32'h7777_7777, 1'b0, 5};

        // Reset with both requests active and RAM claiming ACCESS.
        RST = 1'b1;
        iREN = 1'b1; iaddr = 32'h100;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h200; dstore = 32'h0;
        ramstate = ACCESS; ramload = 32'hA5A5_0001;
        #3;
        check("rst ramREN", ramREN, 1'b0);
        check("rst ramWEN", ramWEN, 1'b0);
        check("rst ramaddr", ramaddr, 32'h0);
        check("rst ramstore", ramstore, 32'h0);
        check("rst iwait", iwait, 1'b1);
        check("rst dwait", dwait, 1'b1);
        check("rst iload", iload, 32'h0);
        check("rst dload", dload, 32'h0);
        check("rst bus_err", bus_err, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("no early grant", ramREN, 1'b0);

        // Simultaneous requests: data first, then fetch.
        @(negedge CLK);
        check("sim1 ramREN", ramREN, 1'b1);
        check("sim1 ramaddr", ramaddr, 32'h200);
        check("sim1 dwait", dwait, 1'b0);
        check("sim1 dload", dload, 32'hA5A5_0001);
        check("sim1 iwait", iwait, 1'b1);
        dREN = 1'b0;
        @(negedge CLK);
        check("sim idle ramREN", ramREN, 1'b0);
        check("sim idle iwait", iwait, 1'b1);
        check("sim idle dwait", dwait, 1'b1);
        @(negedge CLK);
        check("sim2 ramaddr", ramaddr, 32'h100);
        check("sim2 iwait", iwait, 1'b0);
        check("sim2 iload", iload, 32'hA5A5_0001);
        check("sim2 dwait", dwait, 1'b1);
        iREN = 1'b0;
        @(negedge CLK);
        check("sim exit ramREN", ramREN, 1'b0);
        ramstate = FREE;

        // Single-transaction table.
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Fairness: both requests held; expect D D D D I D D D D I.
        pat = 10'b10_0001_0000;
        iREN = 1'b1; iaddr = 32'h100;
        dREN = 1'b1; daddr = 32'h800;
        ramstate = ACCESS; ramload = 32'hF0F0_F0F0;
        g = 0;
        cyc = 0;
        while (g < 10 && cyc < 60) begin
            @(negedge CLK);
            if (ramREN) begin
                is_f = (ramaddr == 32'h100);
                check($sformatf("fair grant %0d is_fetch", g), is_f, pat[g]);
                if (is_f) begin
                    check($sformatf("fair grant %0d iwait", g), iwait, 1'b0);
                end else begin
                    check($sformatf("fair grant %0d dwait", g), dwait, 1'b0);
                    daddr = daddr + 32'h4;
                end
                g++;
            end
            cyc++;
        end
        check("fair grant count", g, 10);
        iREN = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        ramstate = FREE;
        @(negedge CLK);
        check("fair exit ramREN", ramREN, 1'b0);

        // Reset while serving a data read held in BUSY.
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        @(negedge CLK);
        check("mid ramREN before", ramREN, 1'b1);
        check("mid ramaddr before", ramaddr, 32'h300);
        check("mid dwait before", dwait, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        check("mid ramREN async", ramREN, 1'b0);
        check("mid dwait async", dwait, 1'b1);
        check("mid ramaddr async", ramaddr, 32'h0);
        ramstate = ACCESS;
        @(negedge CLK);
        check("mid dwait in reset", dwait, 1'b1);
        dREN = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        check("mid dwait after", dwait, 1'b1);
        check("mid ramREN after", ramREN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
